// File: rtl/serial_pe_pkg.sv
// ============================================================================
// Module : serial_pe_pkg
// Brief  : Shared constants and accumulate-FSM encoding for the serial PE.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_pe_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ACC_W    = 20;
    localparam int DEF_NUM_TAPS = 9;
    localparam int PROD_W       = 2 * DEF_DATA_W;

    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_pe_accumulator_if.sv
// ============================================================================
// Module : serial_pe_accumulator_if
// Brief  : Operand feed from the loader and result handshake to the writer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_pe_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);

    logic [DATA_W-1:0] w_in;
    logic [DATA_W-1:0] f_in;
    logic              acc_en;
    logic              rst_pe;
    logic [ACC_W-1:0]  result_o;
    logic              result_valid_o;
    logic              result_ready_i;
    logic [7:0]        tap_cnt_o;
    logic              overrun_o;
    logic              busy_o;

    modport master (
        output w_in, f_in, acc_en, rst_pe, result_ready_i,
        input  result_o, result_valid_o, tap_cnt_o, overrun_o, busy_o
    );

    modport slave (
        input  w_in, f_in, acc_en, rst_pe, result_ready_i,
        output result_o, result_valid_o, tap_cnt_o, overrun_o, busy_o
    );

endinterface

`default_nettype wire

// File: rtl/serial_pe_accumulator_mac_unit.sv
// ============================================================================
// Module : serial_mac_unit
// Brief  : Combinational multiply, extend and add. Build option
//          SERIAL_PE_SIGNED_EN selects two's-complement operands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  wire logic [DATA_W-1:0] w_in,
    input  wire logic [DATA_W-1:0] f_in,
    input  wire logic [ACC_W-1:0]  acc_in,
    output logic      [ACC_W-1:0]  sum
);

    localparam int MUL_W = 2 * DATA_W;

`ifdef SERIAL_PE_SIGNED_EN
    logic signed [MUL_W-1:0] w_prod;
    // Size casts keep signedness, so operands and product sign-extend here.
    assign w_prod = MUL_W'($signed(w_in)) * MUL_W'($signed(f_in));
`else
    logic [MUL_W-1:0] w_prod;
    assign w_prod = MUL_W'(w_in) * MUL_W'(f_in);
`endif

    assign sum = acc_in + ACC_W'(w_prod);

endmodule

`default_nettype wire

// File: rtl/serial_pe_accumulator.sv
// ============================================================================
// Module : serial_pe_accumulator
// Brief  : Serial MAC over NUM_TAPS products with a one-entry result register.
//          Build option SERIAL_PE_SIGNED_EN (see serial_mac_unit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_pe_accumulator
    import serial_pe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int NUM_TAPS = DEF_NUM_TAPS
) (
    input wire logic                clk,
    input wire logic                rst,
    serial_pe_accumulator_if.slave  bus
);

    localparam logic [7:0] LAST_TAP = 8'(NUM_TAPS);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [ACC_W-1:0] w_mac_base;
    logic [ACC_W-1:0] w_sum;
    logic [7:0]       r_tap_cnt;
    logic [7:0]       w_tap_cnt_nxt;
    logic [7:0]       w_tap_inc;
    logic             w_complete;
    logic [ACC_W-1:0] r_result;
    logic             r_result_valid;
    logic             r_overrun;

    // A fresh window always starts from zero, independent of stale acc.
    assign w_mac_base = (r_state == ACC_RUN) ? r_acc : '0;
    assign w_tap_inc  = r_tap_cnt + 8'd1;

    serial_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .w_in   (bus.w_in),
        .f_in   (bus.f_in),
        .acc_in (w_mac_base),
        .sum    (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ACC_IDLE;
            r_acc     <= '0;
            r_tap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_tap_cnt <= w_tap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_tap_cnt_nxt = r_tap_cnt;
        w_complete    = 1'b0;
        if (bus.rst_pe) begin
            w_state_nxt   = ACC_IDLE;
            w_acc_nxt     = '0;
            w_tap_cnt_nxt = '0;
        end else if (bus.acc_en) begin
            if (w_tap_inc == LAST_TAP) begin
                w_complete    = 1'b1;
                w_state_nxt   = ACC_IDLE;
                w_acc_nxt     = '0;
                w_tap_cnt_nxt = '0;
            end else begin
                w_state_nxt   = ACC_RUN;
                w_acc_nxt     = w_sum;
                w_tap_cnt_nxt = w_tap_inc;
            end
        end
    end

    // Completion against a full, unread entry drops the new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (w_complete) begin
            if (!r_result_valid || bus.result_ready_i) begin
                r_result       <= w_sum;
                r_result_valid <= 1'b1;
            end else begin
                r_overrun      <= 1'b1;
            end
        end else if (r_result_valid && bus.result_ready_i) begin
            r_result_valid <= 1'b0;
        end
    end

    assign bus.result_o       = r_result;
    assign bus.result_valid_o = r_result_valid;
    assign bus.tap_cnt_o      = r_tap_cnt;
    assign bus.overrun_o      = r_overrun;
    assign bus.busy_o         = (r_tap_cnt != 8'd0);

endmodule

`default_nettype wire
